// File: rtl/irq_pending_ctrl.sv
// Interrupt pending/mask front end with a valid/ack offer and in-service tracking.
// Define IRQ_EDGE_DETECT_EN for rising-edge requests; the default build is level-sensitive.
module irq_pending_ctrl #(
    parameter int N    = 8,
    parameter int ID_W = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic            mask_we,
    input  logic [N-1:0]    mask_wdata,
    input  logic            irq_ack,
    input  logic            eoi,
    output logic            irq_valid,
    output logic [ID_W-1:0] irq_id,
    output logic            in_service,
    output logic [N-1:0]    pending
);

    typedef enum logic [1:0] {IDLE, OFFER, SERVICE} state_t;

    state_t          state, state_nxt;
    logic [N-1:0]    mask;
    logic [N-1:0]    set;
    logic [N-1:0]    clr;
    logic [N-1:0]    eligible;
    logic [ID_W-1:0] winner;
    logic            load_id;
    logic            accept;

`ifdef IRQ_EDGE_DETECT_EN
    logic [N-1:0] req_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) req_q <= '0;
        else     req_q <= req;
    end

    assign set = req & ~req_q;
`else
    assign set = req;
`endif

    assign eligible = pending & ~mask;
    // Only an accepted ack clears; a same-cycle set on that bit survives the clear.
    assign clr      = accept ? (N'(1) << irq_id) : '0;

    // Highest index wins, matching the downstream encoder's priority.
    always_comb begin
        winner = '0;
        for (int i = 0; i < N; i++)
            if (eligible[i]) winner = ID_W'(i);
    end

    always_comb begin
        state_nxt = state;
        load_id   = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (|eligible) begin
                    state_nxt = OFFER;
                    load_id   = 1'b1;
                end
            end
            OFFER: begin
                if (irq_ack) begin
                    state_nxt = SERVICE;
                    accept    = 1'b1;
                end
            end
            SERVICE: begin
                if (eoi) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            pending <= '0;
            mask    <= '1;
            irq_id  <= '0;
        end else begin
            state   <= state_nxt;
            pending <= (pending & ~clr) | set;
            if (mask_we) mask <= mask_wdata;
            // irq_id is held through OFFER and keeps its value afterwards.
            if (load_id) irq_id <= winner;
        end
    end

    assign irq_valid  = (state == OFFER);
    assign in_service = (state == SERVICE);

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Directed bench for irq_pending_ctrl: per-cycle comparison against a rule-level model
// plus hand-computed checkpoints.
module tb_irq_pending_ctrl;
    localparam int N = 8;
    localparam int ID_W = 3;
`ifdef IRQ_EDGE_DETECT_EN
    localparam bit LEVEL = 1'b0;
`else
    localparam bit LEVEL = 1'b1;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req = '0;
    logic            mask_we = 1'b0;
    logic [N-1:0]    mask_wdata = '0;
    logic            irq_ack = 1'b0;
    logic            eoi = 1'b0;
    logic            irq_valid;
    logic [ID_W-1:0] irq_id;
    logic            in_service;
    logic [N-1:0]    pending;

    int total = 0;
    int bad = 0;

    irq_pending_ctrl #(.N(N), .ID_W(ID_W)) dut (
        .clk(clk), .rst(rst), .req(req), .mask_we(mask_we), .mask_wdata(mask_wdata),
        .irq_ack(irq_ack), .eoi(eoi), .irq_valid(irq_valid), .irq_id(irq_id),
        .in_service(in_service), .pending(pending)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: a pending set, a mask, and two flags saying whether an offer or a service is open.
    logic [N-1:0] m_pend, m_mask, m_prev_req;
    bit           m_offer, m_serv;
    int           m_id;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pend = '0; m_mask = '1; m_prev_req = '0;
            m_offer = 0; m_serv = 0; m_id = 0;
        end else begin
            logic [N-1:0] s, e, np;
            s = LEVEL ? req : (req & ~m_prev_req);
            e = m_pend & ~m_mask;
            np = m_pend;
            if (!m_offer && !m_serv) begin
                if (e != 0) begin
                    for (int i = N - 1; i >= 0; i--)
                        if (e[i]) begin m_id = i; break; end
                    m_offer = 1;
                end
            end else if (m_offer) begin
                if (irq_ack) begin
                    np[m_id] = 1'b0;
                    m_offer = 0;
                    m_serv = 1;
                end
            end else if (eoi) begin
                m_serv = 0;
            end
            m_pend = np | s;
            if (mask_we) m_mask = mask_wdata;
            m_prev_req = req;
        end
    end

    always @(negedge clk) begin
        check("model_valid", 32'(irq_valid), 32'(m_offer));
        check("model_in_service", 32'(in_service), 32'(m_serv));
        check("model_id", 32'(irq_id), 32'(m_id));
        check("model_pending", 32'(pending), 32'(m_pend));
    end

    task automatic step(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_req(input logic [N-1:0] v);
        req = v; step(); req = '0;
    endtask

    task automatic write_mask(input logic [N-1:0] v);
        mask_we = 1'b1; mask_wdata = v; step(); mask_we = 1'b0;
    endtask

    task automatic do_ack();
        irq_ack = 1'b1; step(); irq_ack = 1'b0;
    endtask

    task automatic do_eoi();
        eoi = 1'b1; step(); eoi = 1'b0;
    endtask

    // Serve everything outstanding, bounded so a stuck DUT still reaches the summary.
    task automatic drain();
        int quiet = 0;
        for (int k = 0; k < 60 && quiet < 3; k++) begin
            if (irq_valid) begin do_ack(); quiet = 0; end
            else if (in_service) begin do_eoi(); quiet = 0; end
            else begin step(); quiet++; end
        end
        check("drain_quiet", 32'(quiet >= 3), 32'd1);
    endtask

    initial begin
        step(3);
        rst = 1'b0;
        step();
        check("rst_valid", 32'(irq_valid), 32'd0);
        check("rst_id", 32'(irq_id), 32'd0);
        check("rst_in_service", 32'(in_service), 32'd0);
        check("rst_pending", 32'(pending), 32'd0);

        // single request
        write_mask(8'h00);
        pulse_req(8'h80);
        check("t1_pending", 32'(pending), 32'h80);
        check("t1_no_early_valid", 32'(irq_valid), 32'd0);
        step();
        check("t1_valid", 32'(irq_valid), 32'd1);
        check("t1_id", 32'(irq_id), 32'd7);
        do_ack();
        check("t1_ack_pending", 32'(pending), 32'h00);
        check("t1_ack_valid", 32'(irq_valid), 32'd0);
        check("t1_ack_in_service", 32'(in_service), 32'd1);
        do_eoi();
        check("t1_eoi_in_service", 32'(in_service), 32'd0);
        step();
        check("t1_idle_valid", 32'(irq_valid), 32'd0);

        // simultaneous requests
        pulse_req(8'h30);
        step();
        check("t2_first_id", 32'(irq_id), 32'd5);
        do_ack();
        check("t2_pending_after_ack", 32'(pending), 32'h10);
        do_eoi();
        step();
        check("t2_second_valid", 32'(irq_valid), 32'd1);
        check("t2_second_id", 32'(irq_id), 32'd4);
        do_ack(); do_eoi();
        check("t2_pending_empty", 32'(pending), 32'h00);

        // masking
        write_mask(8'h40);
        pulse_req(8'h44);
        step();
        check("t3_valid", 32'(irq_valid), 32'd1);
        check("t3_id", 32'(irq_id), 32'd2);
        do_ack();
        check("t3_masked_pending", 32'(pending), 32'h40);
        write_mask(8'h00);
        check("t3_still_service", 32'(in_service), 32'd1);
        do_eoi();
        step();
        check("t3_unmasked_valid", 32'(irq_valid), 32'd1);
        check("t3_unmasked_id", 32'(irq_id), 32'd6);
        do_ack(); do_eoi();

        // offer stability
        pulse_req(8'h08);
        step();
        check("t4_id3", 32'(irq_id), 32'd3);
        pulse_req(8'h80);
        check("t4_hold_id", 32'(irq_id), 32'd3);
        check("t4_pending", 32'(pending), 32'h88);
        step();
        check("t4_hold_valid", 32'(irq_valid), 32'd1);
        check("t4_hold_id2", 32'(irq_id), 32'd3);
        do_ack();
        check("t4_pending_after_ack", 32'(pending), 32'h80);
        do_eoi();
        step();
        check("t4_next_id", 32'(irq_id), 32'd7);
        check("t4_next_valid", 32'(irq_valid), 32'd1);
        do_ack(); do_eoi();

        // held request
        req = 8'h02;
        step(2);
        check("t5_first_valid", 32'(irq_valid), 32'd1);
        check("t5_first_id", 32'(irq_id), 32'd1);
        do_ack(); do_eoi();
        step();
        check("t5_reoffer1", 32'(irq_valid), 32'(LEVEL));
        if (irq_valid) do_ack(); else step();
        if (in_service) do_eoi(); else step();
        step();
        check("t5_reoffer2", 32'(irq_valid), 32'(LEVEL));
        check("t5_pending_held", 32'(pending), LEVEL ? 32'h02 : 32'h00);
        req = '0;
        drain();

        // request edge coinciding with its own ack
        pulse_req(8'h01);
        step();
        check("t6_id0", 32'(irq_id), 32'd0);
        req = 8'h01; irq_ack = 1'b1;
        step();
        req = '0; irq_ack = 1'b0;
        check("t6_kept_pending", 32'(pending), 32'h01);
        check("t6_in_service", 32'(in_service), 32'd1);
        do_eoi();
        step();
        check("t6_reoffer_valid", 32'(irq_valid), 32'd1);
        check("t6_reoffer_id", 32'(irq_id), 32'd0);
        drain();
        check("t6_pending_empty", 32'(pending), 32'h00);

        // reset mid-service
        pulse_req(8'h19);
        step();
        check("t7_id4", 32'(irq_id), 32'd4);
        do_ack();
        check("t7_pending", 32'(pending), 32'h09);
        check("t7_in_service", 32'(in_service), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("t7_async_valid", 32'(irq_valid), 32'd0);
        check("t7_async_in_service", 32'(in_service), 32'd0);
        check("t7_async_id", 32'(irq_id), 32'd0);
        check("t7_async_pending", 32'(pending), 32'h00);
        step(2);
        rst = 1'b0;
        pulse_req(8'h01);
        step(2);
        check("t7_masked_valid", 32'(irq_valid), 32'd0);
        check("t7_masked_pending", 32'(pending), 32'h01);
        write_mask(8'h00);
        step();
        check("t7_unmask_valid", 32'(irq_valid), 32'd1);
        check("t7_unmask_id", 32'(irq_id), 32'd0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/irq_pending_ctrl.md
# irq_pending_ctrl

Sequential front end that sits directly upstream of the 8-to-3 priority encoder stage. It captures up to eight interrupt request lines into a pending register and applies a software mask. It selects the highest-index unmasked pending request using the same priority order as the encoder (bit 7 highest). It then presents the request as a registered `irq_id` with a valid/ack handshake and tracks the in-service interval until end-of-interrupt.

## Interface
Parameters:
- `N`, 8, number of request lines.
- `ID_W`, 3, width of `irq_id`. Must satisfy 2^ID_W = N.

Ports:
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `req` in N: raw request lines, synchronous to `clk`.
- `mask_we` in 1: mask write strobe.
- `mask_wdata` in N: new mask value; 1 = masked.
- `irq_ack` in 1: consumer accepts the offered id.
- `eoi` in 1: end of interrupt for the in-service id.
- `irq_valid` out 1: an id is being offered.
- `irq_id` out ID_W: offered id (index of winning bit).
- `in_service` out 1: an acknowledged interrupt is being serviced.
- `pending` out N: current pending register.

## Operation
- Set vector `set`:
  - With edge detect compiled in: `req & ~req_q`, where `req_q` is `req` registered.
  - Otherwise: `req`.
- Pending update each edge: `pending <= (pending & ~clr) | set`. `clr` is a one-hot of `irq_id` when an ack is accepted. Set wins over clear on the same bit.
- Eligible vector: `pending & ~mask`. Winner is the highest set index.
- Mask: `mask <= mask_wdata` on an edge with `mask_we`. The new mask is used from the next edge's decision.
- FSM states: IDLE, OFFER, SERVICE.
  - IDLE: if eligible is non-zero, load `irq_id` with the winner, set `irq_valid`, and go to OFFER. Otherwise stay.
  - OFFER: `irq_valid` and `irq_id` are held stable regardless of new requests or mask changes; the offer is never withdrawn. On `irq_ack`:
    - clear `pending[irq_id]`;
    - drop `irq_valid`;
    - set `in_service`;
    - go to SERVICE.
  - SERVICE: on `eoi`, drop `in_service` and go to IDLE. No nesting or preemption.
- `irq_ack` outside OFFER is ignored. `eoi` outside SERVICE is ignored.
- `irq_id` retains its last value after the offer ends.

## Timing
- Reset values:
  - `pending` = 0
  - `mask` = all ones (everything masked)
  - `req_q` = 0
  - state = IDLE
  - `irq_valid` = 0
  - `irq_id` = 0
  - `in_service` = 0
- Request latency: `req[i]` first sampled high at edge t gives `pending[i]` = 1 after t. If unmasked and in IDLE, `irq_valid` = 1 with `irq_id` = i after edge t+1.
- Ack: `irq_ack` sampled at edge a in OFFER gives, after a, `irq_valid` = 0, `in_service` = 1, and the served pending bit cleared.
- EOI: `eoi` sampled at edge e in SERVICE gives `in_service` = 0 after e. The earliest next offer is after e+1.
- Minimum spacing between consecutive offers is 3 cycles (ack, eoi, decide).
- A request edge on the bit being acknowledged in the same cycle leaves that bit pending; it is offered again after EOI.
- Reset asserted mid-operation forces all reset values immediately, independent of `clk`.

## Configuration
- `IRQ_EDGE_DETECT_EN` defined:
  - Requests are rising-edge triggered.
  - A line held high produces exactly one pending event.
  - The `req_q` register is present.
- Not defined:
  - Requests are level-sensitive.
  - A line held high re-sets its pending bit every cycle, so it is re-offered after each EOI.
  - No `req_q` register.

## Test plan
- Single request: reset, write mask 8'h00, pulse `req` = 8'b10000000 for 1 cycle. Expect `irq_valid` = 1 with `irq_id` = 7 two edges later. Ack gives `pending` = 0 and `in_service` = 1. EOI gives `in_service` = 0 and state IDLE.
- Simultaneous requests: mask 8'h00, `req` = 8'b00110000. Expect id 5 offered first. After ack/EOI, id 4 is offered. Afterwards `pending` = 0.
- Masking: mask = 8'b01000000, `req` = 8'b01000100. Expect id 2 offered and `pending[6]` staying 1. Write mask 8'h00 during SERVICE; after EOI expect id 6 offered.
- Offer stability: id 3 offered, then `req[7]` rises before ack. Expect `irq_id` to stay 3 until ack, then id 7 offered after EOI.
- Held request: `req` = 8'b00000010 held high across two full ack/EOI sequences.
  - With `IRQ_EDGE_DETECT_EN`: exactly one offer of id 1.
  - Without it: id 1 re-offered after each EOI.
- Reset mid-service: assert `rst` while `in_service` = 1 and `pending` = 8'b00001001. Expect all outputs 0 immediately, and mask all ones after release (no offer until the mask is rewritten).
